// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I controller: opcodes, control-field codes and FSM states.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {EXEC, MEM_WAIT} ctrl_state_t;

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU operation select from opcode, funct3 and funct7[5].
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          // Only the register form can subtract; addi ignores bit 30.
          3'b000:  alu_control = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      OP_BEQ:  alu_control = ALU_SUB;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mem_ctrl_fsm.sv
// RV32I main decoder with a two-state sequencer that stalls the PC across a
// req/ready data-memory access and abandons it after TIMEOUT wait cycles.
module riscv_mem_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        PCEn,
  output logic        PCSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        mem_req,
  output logic [2:0]  ALUControl,
  output logic [2:0]  DataSrc,
  output logic        illegal_instr,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_beq, is_jal;
  logic       is_legal, is_mem, dec_reg_write;
  logic       unused_instr_bits;

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;

  assign opcode            = Instr[6:0];
  assign funct3            = Instr[14:12];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_jal   = (opcode == OP_JAL);
  assign is_mem   = is_load | is_store;
  assign is_legal = is_r | is_i | is_mem | is_beq | is_jal;

  riscv_alu_decoder u_alu_dec (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (Instr[30]),
    .alu_control (ALUControl)
  );

  always_comb begin
    ResultSrc     = RES_ALU;
    ALUSrc        = 1'b0;
    ImmSrc        = IMM_I;
    dec_reg_write = 1'b0;
    case (opcode)
      OP_R:     dec_reg_write = 1'b1;
      OP_I:     begin ALUSrc = 1'b1; dec_reg_write = 1'b1; end
      OP_LOAD:  begin ALUSrc = 1'b1; ResultSrc = RES_MEM; end
      OP_STORE: begin ALUSrc = 1'b1; ImmSrc = IMM_S; end
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   begin ImmSrc = IMM_J; ResultSrc = RES_PC4; dec_reg_write = 1'b1; end
      default:  ;
    endcase
  end

  assign PCSrc   = is_jal | (is_beq & zero_flag);
  assign DataSrc = funct3;
  assign bus_err = bus_err_q;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    bus_err_d     = bus_err_q;
    PCEn          = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    mem_req       = 1'b0;
    illegal_instr = ~is_legal;
    case (state_q)
      EXEC: begin
        // mem_ready is deliberately ignored here, so accesses take at least two cycles.
        if (is_mem) begin
          mem_req    = 1'b1;
          MemWrite   = is_store;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          PCEn     = 1'b1;
          RegWrite = dec_reg_write;
        end
      end
      MEM_WAIT: begin
        mem_req  = 1'b1;
        MemWrite = is_store;
        if (mem_ready) begin
          PCEn     = 1'b1;
          RegWrite = is_load;
          state_d  = EXEC;
        end else if (wait_cnt_q == LAST_WAIT) begin
          PCEn      = 1'b1;
          bus_err_d = 1'b1;
          state_d   = EXEC;
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    endcase
    if (Reset) begin
      PCEn          = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      mem_req       = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= EXEC;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_ctrl_fsm.sv
// Directed bench for riscv_mem_ctrl_fsm: a cycle-level reference model checked on
// every negedge, plus hand-computed expectations after each directed step.
module tb_riscv_mem_ctrl_fsm;

  localparam int TIMEOUT = 15;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADD    = 32'h002081B3;
  localparam logic [31:0] SUB    = 32'h402081B3;
  localparam logic [31:0] AND_R  = 32'h0020F1B3;
  localparam logic [31:0] OR_R   = 32'h0020E1B3;
  localparam logic [31:0] SLT_R  = 32'h0020A1B3;
  localparam logic [31:0] ADDI30 = 32'h40008093;
  localparam logic [31:0] LB     = 32'h83000083;
  localparam logic [31:0] LW     = 32'h0000A083;
  localparam logic [31:0] SW     = 32'h0471AA23;
  localparam logic [31:0] BEQ    = 32'h00208463;
  localparam logic [31:0] JAL    = 32'h0080006F;
  localparam logic [31:0] BADOP  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr = NOP;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCEn, PCSrc, ALUSrc, RegWrite, MemWrite, mem_req, illegal_instr, bus_err;
  logic [1:0]  ResultSrc, ImmSrc;
  logic [2:0]  ALUControl, DataSrc;

  always #5 clk = ~clk;

  riscv_mem_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .zero_flag     (zero_flag),
    .mem_ready     (mem_ready),
    .PCEn          (PCEn),
    .PCSrc         (PCSrc),
    .ResultSrc     (ResultSrc),
    .ALUSrc        (ALUSrc),
    .ImmSrc        (ImmSrc),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .mem_req       (mem_req),
    .ALUControl    (ALUControl),
    .DataSrc       (DataSrc),
    .illegal_instr (illegal_instr),
    .bus_err       (bus_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A negative expectation means the field is unconstrained for this instruction.
  task automatic chk_opt(input string name, input logic [31:0] act, input int exp);
    if (exp >= 0) chk(name, act, exp);
  endtask

  function automatic int alu_of(input logic [2:0] f3, input logic sub_bit);
    case (f3)
      3'b000:  return sub_bit ? 1 : 0;
      3'b111:  return 2;
      3'b110:  return 3;
      3'b010:  return 5;
      default: return -1;
    endcase
  endfunction

  // Reference model: whether an access is outstanding and how many wait cycles it has used.
  bit m_en = 1'b0;
  bit m_busy = 1'b0;
  int m_waits = 0;
  bit m_buserr = 1'b0;

  always @(posedge clk) begin
    if (Reset) begin
      m_en     <= 1'b1;
      m_busy   <= 1'b0;
      m_waits  <= 0;
      m_buserr <= 1'b0;
    end else if (!m_busy) begin
      if (Instr[6:0] == 7'b0000011 || Instr[6:0] == 7'b0100011) begin
        m_busy  <= 1'b1;
        m_waits <= 0;
      end
    end else if (mem_ready) begin
      m_busy <= 1'b0;
    end else if (m_waits == TIMEOUT - 1) begin
      m_busy   <= 1'b0;
      m_buserr <= 1'b1;
    end else begin
      m_waits <= m_waits + 1;
    end
  end

  int e_rs, e_asrc, e_imm, e_alu, e_ds, e_pcsrc, e_pcen, e_rw, e_mw, e_req, e_ill, e_rwdec;
  bit is_ld, is_st, legal;

  always @(negedge clk) begin
    if (m_en) begin
      e_rs = -1; e_asrc = -1; e_imm = -1; e_alu = -1; e_ds = -1; e_rwdec = 0;
      is_ld = (Instr[6:0] == 7'b0000011);
      is_st = (Instr[6:0] == 7'b0100011);
      legal = 1'b1;
      case (Instr[6:0])
        7'b0110011: begin e_rs = 0; e_asrc = 0; e_alu = alu_of(Instr[14:12], Instr[30]); e_rwdec = 1; end
        7'b0010011: begin e_rs = 0; e_asrc = 1; e_imm = 0; e_alu = alu_of(Instr[14:12], 1'b0); e_rwdec = 1; end
        7'b0000011: begin e_rs = 1; e_asrc = 1; e_imm = 0; e_alu = 0; e_ds = int'(Instr[14:12]); end
        7'b0100011: begin e_asrc = 1; e_imm = 1; e_alu = 0; e_ds = int'(Instr[14:12]); end
        7'b1100011: begin e_asrc = 0; e_imm = 2; e_alu = 1; end
        7'b1101111: begin e_rs = 2; e_imm = 3; e_rwdec = 1; end
        default:    legal = 1'b0;
      endcase
      e_pcsrc = (Instr[6:0] == 7'b1101111 || (Instr[6:0] == 7'b1100011 && zero_flag)) ? 1 : 0;
      if (Reset) begin
        e_pcen = 0; e_rw = 0; e_mw = 0; e_req = 0; e_ill = 0;
      end else if (!m_busy && !(is_ld || is_st)) begin
        e_pcen = 1; e_rw = legal ? e_rwdec : 0; e_mw = 0; e_req = 0; e_ill = legal ? 0 : 1;
      end else if (!m_busy) begin
        e_pcen = 0; e_rw = 0; e_mw = is_st; e_req = 1; e_ill = 0;
      end else begin
        e_req = 1; e_mw = is_st; e_ill = 0;
        if (mem_ready) begin e_pcen = 1; e_rw = is_ld; end
        else if (m_waits == TIMEOUT - 1) begin e_pcen = 1; e_rw = 0; end
        else begin e_pcen = 0; e_rw = 0; end
      end
      chk("mdl.PCEn", PCEn, e_pcen);
      chk("mdl.RegWrite", RegWrite, e_rw);
      chk("mdl.MemWrite", MemWrite, e_mw);
      chk("mdl.mem_req", mem_req, e_req);
      chk("mdl.illegal_instr", illegal_instr, e_ill);
      chk("mdl.bus_err", bus_err, m_buserr);
      chk("mdl.PCSrc", PCSrc, e_pcsrc);
      chk_opt("mdl.ResultSrc", ResultSrc, e_rs);
      chk_opt("mdl.ALUSrc", ALUSrc, e_asrc);
      chk_opt("mdl.ImmSrc", ImmSrc, e_imm);
      chk_opt("mdl.ALUControl", ALUControl, e_alu);
      chk_opt("mdl.DataSrc", DataSrc, e_ds);
    end
  end

  task automatic step(input logic rst, input logic [31:0] ins, input logic zf, input logic rdy);
    @(posedge clk);
    #1;
    Reset = rst; Instr = ins; zero_flag = zf; mem_ready = rdy;
    #2;
  endtask

  initial begin
    step(1'b1, NOP, 1'b0, 1'b0);
    step(1'b1, NOP, 1'b0, 1'b0);
    chk("rst.PCEn", PCEn, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.RegWrite", RegWrite, 0);

    step(1'b0, ADD, 1'b0, 1'b0);
    chk("add.bus_err", bus_err, 0);
    chk("add.PCEn", PCEn, 1);
    chk("add.RegWrite", RegWrite, 1);
    chk("add.ALUControl", ALUControl, 3'b000);
    chk("add.ResultSrc", ResultSrc, 2'b00);
    chk("add.ALUSrc", ALUSrc, 0);
    step(1'b0, SUB, 1'b0, 1'b0);
    chk("sub.ALUControl", ALUControl, 3'b001);
    step(1'b0, AND_R, 1'b0, 1'b0);
    chk("and.ALUControl", ALUControl, 3'b010);
    step(1'b0, OR_R, 1'b0, 1'b0);
    chk("or.ALUControl", ALUControl, 3'b011);
    step(1'b0, SLT_R, 1'b0, 1'b0);
    chk("slt.ALUControl", ALUControl, 3'b101);
    step(1'b0, ADDI30, 1'b0, 1'b0);
    chk("addi.ALUControl", ALUControl, 3'b000);
    chk("addi.ALUSrc", ALUSrc, 1);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, LB, 1'b0, i == 4);
      chk("lb.mem_req", mem_req, 1);
      chk("lb.PCEn", PCEn, i == 4);
      chk("lb.RegWrite", RegWrite, i == 4);
      chk("lb.ResultSrc", ResultSrc, 2'b01);
    end
    chk("lb.DataSrc", DataSrc, 3'b000);
    chk("lb.ImmSrc", ImmSrc, 2'b00);
    step(1'b0, ADD, 1'b0, 1'b0);
    chk("lb.after.mem_req", mem_req, 0);

    for (int i = 0; i < 2; i++) begin
      step(1'b0, SW, 1'b0, 1'b1);
      chk("sw.MemWrite", MemWrite, 1);
      chk("sw.PCEn", PCEn, i == 1);
      chk("sw.RegWrite", RegWrite, 0);
      chk("sw.ImmSrc", ImmSrc, 2'b01);
      chk("sw.ALUSrc", ALUSrc, 1);
    end
    step(1'b0, NOP, 1'b0, 1'b0);
    chk("sw.after.MemWrite", MemWrite, 0);

    step(1'b0, BEQ, 1'b1, 1'b0);
    chk("beq.PCSrc", PCSrc, 1);
    chk("beq.ImmSrc", ImmSrc, 2'b10);
    chk("beq.ALUControl", ALUControl, 3'b001);
    step(1'b0, BEQ, 1'b0, 1'b0);
    chk("beq.nz.PCSrc", PCSrc, 0);
    step(1'b0, JAL, 1'b0, 1'b0);
    chk("jal.PCSrc", PCSrc, 1);
    chk("jal.ResultSrc", ResultSrc, 2'b10);
    chk("jal.RegWrite", RegWrite, 1);
    step(1'b0, BADOP, 1'b0, 1'b1);
    chk("ill.illegal_instr", illegal_instr, 1);
    chk("ill.PCEn", PCEn, 1);
    chk("ill.RegWrite", RegWrite, 0);
    chk("ill.mem_req", mem_req, 0);

    // Ready arriving on the last allowed wait cycle completes normally.
    step(1'b0, LW, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      step(1'b0, LW, 1'b0, i == TIMEOUT - 1);
      chk("lwlate.PCEn", PCEn, i == TIMEOUT - 1);
      chk("lwlate.RegWrite", RegWrite, i == TIMEOUT - 1);
    end
    step(1'b0, NOP, 1'b0, 1'b0);
    chk("lwlate.bus_err", bus_err, 0);

    step(1'b0, LW, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      step(1'b0, LW, 1'b0, 1'b0);
      chk("lwto.PCEn", PCEn, i == TIMEOUT - 1);
      chk("lwto.RegWrite", RegWrite, 0);
      chk("lwto.bus_err", bus_err, 0);
    end
    step(1'b0, NOP, 1'b0, 1'b0);
    chk("lwto.bus_err.set", bus_err, 1);
    chk("lwto.after.mem_req", mem_req, 0);

    step(1'b0, LW, 1'b0, 1'b0);
    step(1'b0, LW, 1'b0, 1'b0);
    step(1'b0, LW, 1'b0, 1'b0);
    step(1'b1, LW, 1'b0, 1'b1);
    chk("rstmid.mem_req", mem_req, 0);
    chk("rstmid.RegWrite", RegWrite, 0);
    chk("rstmid.PCEn", PCEn, 0);
    step(1'b0, NOP, 1'b0, 1'b0);
    chk("rstmid.bus_err", bus_err, 0);
    chk("rstmid.after.mem_req", mem_req, 0);
    chk("rstmid.after.PCEn", PCEn, 1);

    step(1'b0, NOP, 1'b0, 1'b0);
    @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
